riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Memory (MEM) stage of the riscv_core pipeline, directly downstream of execute (EX) and upstream of writeback (WB). Accepts one EX result per handshake. Non-memory results pass straight through to WB. Loads and stores go to data memory with byte-lane alignment, write strobes and load sign/zero extension, with one outstanding transaction at a time.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)

Ports:
clk_in  input  1  clock
rst_n_in  input  1  synchronous active-low reset
ex_valid_in  input  1  EX result valid
ex_ready_out  output  1  LSU can accept EX result this cycle
ex_op_in  input  2  00 NONE, 01 LOAD, 10 STORE, 11 treated as NONE
ex_funct3_in  input  3  RISC-V width: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_addr_in  input  32  ALU result: memory address, or writeback value for NONE
ex_wdata_in  input  32  store data (rs2)
ex_rd_in  input  5  destination register
mem_req_valid_out  output  1  data memory request valid
mem_req_ready_in  input  1  memory accepts request
mem_we_out  output  1  1 = store
mem_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata_out  output  32  lane-replicated store data
mem_wstrb_out  output  4  byte write strobes (0000 for loads)
mem_rsp_valid_in  input  1  load data valid
mem_rdata_in  input  32  load word
wb_valid_out  output  1  WB result valid
wb_ready_in  input  1  WB accepts result
wb_rd_out  output  5  destination register
wb_data_out  output  32  result / extended load data
wb_exc_out  output  1  misaligned-access exception (see Optional Feature)

Behaviour:
- Reset (rst_n_in=0 at posedge): state IDLE; every output register 0 (all valids, addr, data, strobes, rd, exc). Reset mid-transaction abandons it. mem_rsp_valid_in is ignored in any state other than WAIT.
- The WB output is a single register. It holds until wb_valid_out && wb_ready_in, and its values are stable while valid and not ready.
- ex_ready_out = (state==IDLE) && (!wb_valid_out || wb_ready_in). This is combinational. Accept = ex_valid_in && ex_ready_out.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, accept NONE: next cycle wb_valid_out=1, wb_data_out=ex_addr_in, wb_rd_out=ex_rd_in. Stay in IDLE. Back-to-back NONE gives 1/cycle throughput.
  - IDLE, accept LOAD/STORE: latch the operation; go to REQ.
  - REQ: mem_req_valid_out=1 with registered fields, held stable until mem_req_ready_in. On handshake, a STORE returns to IDLE with no WB output, and a LOAD goes to WAIT.
  - WAIT: on mem_rsp_valid_in, the extracted value is registered into WB (wb_valid_out=1 the next cycle) and the FSM returns to IDLE.
- Minimum latency: a load accepted at cycle 0 with ready/rsp immediate issues its request at cycle 1 and returns rsp at cycle 2, giving wb_valid_out at cycle 3. A store frees the LSU after its request handshake.
- Store lanes, with off = addr[1:0]:
  - B: wstrb = 0001<<off, wdata = {4{wdata[7:0]}}.
  - H: wstrb = 0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}.
  - W: wstrb = 1111.
  - Unlisted funct3 values store as W.
- Load extract: byte = rdata>>(8*off), half = rdata>>(16*addr[1]). B/H sign-extend, BU/HU zero-extend, W unmodified. Other funct3 values behave as W.
- A LOAD with rd=0 still performs the memory access and produces a WB output with wb_rd_out=0. WB discards it.
- When the WB register drains and a new result is written into it in the same cycle, the new result is what appears next cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, issues no memory request. The next cycle gives wb_valid_out=1, wb_exc_out=1, wb_data_out=faulting address and wb_rd_out=ex_rd_in, and the FSM stays in IDLE.
- Undefined: wb_exc_out is tied to 0. H ignores addr[0], W ignores addr[1:0], and the access proceeds as if aligned.

Test Plan:
- Reset held 2 cycles with wb_ready_in=1, then NONE addr=0x1234, rd=5 -> after reset all outputs 0; one cycle after accept, wb_valid_out=1, wb_data_out=0x00001234, wb_rd_out=5.
- STORE B addr=0x1003, wdata=0xAABBCCDD, mem_req_ready_in=1 -> mem_addr_out=0x1000, wstrb=1000, mem_wdata_out=0xDDDDDDDD, mem_we_out=1; no wb_valid_out.
- LOAD B addr=0x2002, rdata=0x00800000 -> wb_data_out=0xFFFFFF80. The same access as BU -> 0x00000080. LOAD HU addr=0x2002, rdata=0xBEEF0000 -> 0x0000BEEF.
- LOAD W with mem_req_ready_in low for 3 cycles and rsp 4 cycles later -> request fields stable throughout, ex_ready_out=0 until return, wb_data_out=rdata.
- wb_ready_in=0 while a result is held, plus a new NONE offered -> ex_ready_out=0 and WB values held. Raising wb_ready_in drains the held result and accepts the new NONE in the same cycle.
- With LSU_MISALIGN_TRAP_EN, LOAD W addr=0x3001 -> no mem_req_valid_out; wb_exc_out=1, wb_data_out=0x00003001. Without the macro -> request issues to 0x3000. Reset asserted in WAIT -> a later mem_rsp_valid_in produces no WB output.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: EX-input, data-memory and WB-output handshake bundle of the MEM stage
//   master: LSU side (sinks EX results, issues memory requests, sources WB results)
//   slave:  surrounding pipeline and data memory
interface riscv_lsu_if #(parameter int XLEN = 32);
  logic            ex_valid_in;
  logic            ex_ready_out;
  logic [1:0]      ex_op_in;
  logic [2:0]      ex_funct3_in;
  logic [XLEN-1:0] ex_addr_in;
  logic [XLEN-1:0] ex_wdata_in;
  logic [4:0]      ex_rd_in;
  logic            mem_req_valid_out;
  logic            mem_req_ready_in;
  logic            mem_we_out;
  logic [XLEN-1:0] mem_addr_out;
  logic [XLEN-1:0] mem_wdata_out;
  logic [3:0]      mem_wstrb_out;
  logic            mem_rsp_valid_in;
  logic [XLEN-1:0] mem_rdata_in;
  logic            wb_valid_out;
  logic            wb_ready_in;
  logic [4:0]      wb_rd_out;
  logic [XLEN-1:0] wb_data_out;
  logic            wb_exc_out;
  modport master (
    input  ex_valid_in, ex_op_in, ex_funct3_in, ex_addr_in, ex_wdata_in, ex_rd_in,
    input  mem_req_ready_in, mem_rsp_valid_in, mem_rdata_in, wb_ready_in,
    output ex_ready_out, mem_req_valid_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_wstrb_out, wb_valid_out, wb_rd_out, wb_data_out, wb_exc_out
  );
  modport slave (
    output ex_valid_in, ex_op_in, ex_funct3_in, ex_addr_in, ex_wdata_in, ex_rd_in,
    output mem_req_ready_in, mem_rsp_valid_in, mem_rdata_in, wb_ready_in,
    input  ex_ready_out, mem_req_valid_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_wstrb_out, wb_valid_out, wb_rd_out, wb_data_out, wb_exc_out
  );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: MEM stage - ALU results pass to WB, loads/stores run one at a time on the data bus
//   ports: clk_in, rst_n_in (synchronous, active-low), bus (riscv_lsu_if.master: ex_*, mem_*, wb_*)
//   LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and return wb_exc_out=1 with the address
module riscv_lsu #(parameter int XLEN = 32) (
  input logic         clk_in,
  input logic         rst_n_in,
  riscv_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [4:0]      rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            is_ld, is_st, sz_b, sz_h, trap, accept;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  assign is_ld = bus.ex_op_in == 2'b01;
  assign is_st = bus.ex_op_in == 2'b10;
  // 100/101 are the unsigned load widths; a store with those encodings is treated as W
  assign sz_b = bus.ex_funct3_in == 3'b000 || (is_ld && bus.ex_funct3_in == 3'b100);
  assign sz_h = bus.ex_funct3_in == 3'b001 || (is_ld && bus.ex_funct3_in == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (is_ld || is_st) &&
                ((sz_h && bus.ex_addr_in[0]) || (!sz_b && !sz_h && bus.ex_addr_in[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif
  assign bus.ex_ready_out = state_q == IDLE && (!wb_valid_q || bus.wb_ready_in);
  assign accept = bus.ex_valid_in && bus.ex_ready_out;
  assign ld_b = 8'(bus.mem_rdata_in >> {addr_q[1:0], 3'b000});
  assign ld_h = 16'(bus.mem_rdata_in >> {addr_q[1], 4'b0000});
  assign ld_val = f3_q == 3'b000 ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                  f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, ld_b} :
                  f3_q == 3'b001 ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                  f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, ld_h} : bus.mem_rdata_in;
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rd_d       = rd_q;
    wb_valid_d = wb_valid_q && !bus.wb_ready_in;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    case (state_q)
      IDLE: if (accept) begin
        if ((is_ld || is_st) && !trap) begin
          state_d = REQ;
          we_d    = is_st;
          f3_d    = bus.ex_funct3_in;
          addr_d  = bus.ex_addr_in;
          rd_d    = bus.ex_rd_in;
          wdata_d = sz_b ? {4{bus.ex_wdata_in[7:0]}} : sz_h ? {2{bus.ex_wdata_in[15:0]}} : bus.ex_wdata_in;
          wstrb_d = is_ld ? 4'b0000 : sz_b ? 4'b0001 << bus.ex_addr_in[1:0] :
                    sz_h ? (bus.ex_addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = bus.ex_rd_in;
          wb_data_d  = bus.ex_addr_in;
          wb_exc_d   = trap;
        end
      end
      REQ: if (bus.mem_req_ready_in) state_d = we_q ? IDLE : WAIT;
      WAIT: if (bus.mem_rsp_valid_in) begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = ld_val;
        wb_exc_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end
  assign bus.mem_req_valid_out = state_q == REQ;
  assign bus.mem_we_out        = we_q;
  assign bus.mem_addr_out      = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_wdata_out     = wdata_q;
  assign bus.mem_wstrb_out     = wstrb_q;
  assign bus.wb_valid_out      = wb_valid_q;
  assign bus.wb_rd_out         = wb_rd_q;
  assign bus.wb_data_out       = wb_data_q;
  assign bus.wb_exc_out        = wb_exc_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed plus randomized checks of riscv_lsu against a queue-based reference model
module tb_riscv_lsu;
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    int          rdly;
    int          sdly;
  } req_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          exc;
  } wb_t;
  logic clk = 0;
  logic rst_n = 0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_valid_cyc = 0;
  bit   wb_rand = 0;
  bit   wb_rdy_man = 1;
  bit   noise = 0;
  bit   rsp_busy = 0;
  req_t exp_req[$];
  wb_t  exp_wb[$];
  riscv_lsu_if bus();
  riscv_lsu dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  function automatic int m_sz(input bit ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction
  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int s = m_sz(0, f3);
    int o = int'(a[1:0]);
    if (s == 1) return 4'(1 << o);
    if (s == 2) return 4'(3 << (o / 2 * 2));
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    int s = m_sz(0, f3);
    if (s == 1) return (w & 32'hFF) * 32'h01010101;
    if (s == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int s = m_sz(1, f3);
    int o = int'(a[1:0]);
    logic [31:0] v = r;
    if (s == 1) begin
      v = (r >> (8 * o)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (s == 2) begin
      v = (r >> (16 * (o / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction
  function automatic bit m_mis(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int s = m_sz(ld, f3);
    return (s == 2 && a % 2 != 0) || (s == 4 && a % 4 != 0);
  endfunction
  task automatic push_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] rdata, input int rdly, input int sdly);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.strb = strb; r.rdata = rdata; r.rdly = rdly; r.sdly = sdly;
    exp_req.push_back(r);
  endtask
  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data, input bit exc);
    wb_t e;
    e.rd = rd; e.data = data; e.exc = exc;
    exp_wb.push_back(e);
  endtask
  task automatic drive_ex(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w, input logic [4:0] rd);
    int n = 0;
    bus.ex_valid_in = 1; bus.ex_op_in = op; bus.ex_funct3_in = f3;
    bus.ex_addr_in = a; bus.ex_wdata_in = w; bus.ex_rd_in = rd;
    while (!bus.ex_ready_out && n < 200) begin tick(); n++; end
    chk("ex_accept_timeout", 32'(n < 200), 1);
    acc_cyc = cyc + 1;
    tick();
    bus.ex_valid_in = 0; bus.ex_op_in = 2'($urandom); bus.ex_funct3_in = 3'($urandom);
    bus.ex_addr_in = $urandom; bus.ex_wdata_in = $urandom; bus.ex_rd_in = 5'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(exp_wb.size() == 0 && exp_req.size() == 0 && !rsp_busy && !bus.wb_valid_out &&
             !bus.mem_req_valid_out) && n < 500) begin
      tick(); n++;
    end
    chk("idle_timeout", 32'(n < 500), 1);
  endtask
  initial begin
    bus.wb_ready_in = 1;
    forever begin
      @(negedge clk);
      #1;
      bus.wb_ready_in = wb_rand ? ($urandom_range(0, 3) != 0) : wb_rdy_man;
    end
  end
  initial begin
    wb_t e;
    bit pv = 0;
    forever begin
      tick();
      if (bus.wb_valid_out) begin
        if (!pv) first_valid_cyc = cyc;
        if (exp_wb.size() == 0) chk("wb_spurious", 32'(bus.wb_valid_out), 0);
        else begin
          e = exp_wb[0];
          chk("wb_rd", 32'(bus.wb_rd_out), 32'(e.rd));
          chk("wb_data", bus.wb_data_out, e.data);
          chk("wb_exc", 32'(bus.wb_exc_out), 32'(e.exc));
          if (bus.wb_ready_in) void'(exp_wb.pop_front());
        end
      end
      pv = bus.wb_valid_out;
    end
  end
  initial begin
    req_t r;
    bus.mem_req_ready_in = 0; bus.mem_rsp_valid_in = 0; bus.mem_rdata_in = 0;
    forever begin
      tick();
      bus.mem_rsp_valid_in = noise && $urandom_range(0, 7) == 0;
      bus.mem_rdata_in = $urandom;
      if (bus.mem_req_valid_out) begin
        bus.mem_rsp_valid_in = 0;
        if (exp_req.size() == 0) chk("req_spurious", 32'(bus.mem_req_valid_out), 0);
        else begin
          r = exp_req.pop_front();
          rsp_busy = 1;
          for (int k = 0; k <= r.rdly; k++) begin
            chk("req_valid", 32'(bus.mem_req_valid_out), 1);
            chk("req_we", 32'(bus.mem_we_out), 32'(r.we));
            chk("req_addr", bus.mem_addr_out, r.addr);
            chk("req_strb", 32'(bus.mem_wstrb_out), 32'(r.strb));
            if (r.we) chk("req_wdata", bus.mem_wdata_out, r.wdata);
            bus.mem_req_ready_in = (k == r.rdly);
            tick();
          end
          bus.mem_req_ready_in = 0;
          if (!r.we) begin
            repeat (r.sdly) tick();
            bus.mem_rsp_valid_in = 1; bus.mem_rdata_in = r.rdata;
            tick();
            bus.mem_rsp_valid_in = 0;
          end
          rsp_busy = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, w, rdat;
    logic [4:0]  rd;
    bit          mis;
    int          n;
    bus.ex_valid_in = 0; bus.ex_op_in = 0; bus.ex_funct3_in = 0;
    bus.ex_addr_in = 0; bus.ex_wdata_in = 0; bus.ex_rd_in = 0;
    tick();
    tick();
    chk("rst_req_valid", 32'(bus.mem_req_valid_out), 0);
    chk("rst_we", 32'(bus.mem_we_out), 0);
    chk("rst_addr", bus.mem_addr_out, 0);
    chk("rst_wdata", bus.mem_wdata_out, 0);
    chk("rst_strb", 32'(bus.mem_wstrb_out), 0);
    chk("rst_wb_valid", 32'(bus.wb_valid_out), 0);
    chk("rst_wb_rd", 32'(bus.wb_rd_out), 0);
    chk("rst_wb_data", bus.wb_data_out, 0);
    chk("rst_wb_exc", 32'(bus.wb_exc_out), 0);
    rst_n = 1;
    push_wb(5, 32'h1234, 0);
    drive_ex(2'b00, 3'b000, 32'h1234, 32'h0, 5);
    chk("none_valid", 32'(bus.wb_valid_out), 1);
    chk("none_data", bus.wb_data_out, 32'h00001234);
    chk("none_rd", 32'(bus.wb_rd_out), 5);
    wait_idle();
    chk("none_lat", first_valid_cyc - acc_cyc, 0);
    push_req(1, 32'h1000, 32'hDDDDDDDD, 4'b1000, 0, 0, 0);
    drive_ex(2'b10, 3'b000, 32'h1003, 32'hAABBCCDD, 1);
    wait_idle();
    push_req(0, 32'h2000, 0, 4'b0000, 32'h00800000, 0, 0);
    push_wb(2, 32'hFFFFFF80, 0);
    drive_ex(2'b01, 3'b000, 32'h2002, 32'h0, 2);
    wait_idle();
    chk("ld_lat", first_valid_cyc - acc_cyc, 2);
    push_req(0, 32'h2000, 0, 4'b0000, 32'h00800000, 0, 0);
    push_wb(3, 32'h00000080, 0);
    drive_ex(2'b01, 3'b100, 32'h2002, 32'h0, 3);
    wait_idle();
    push_req(0, 32'h2000, 0, 4'b0000, 32'hBEEF0000, 0, 0);
    push_wb(0, 32'h0000BEEF, 0);
    drive_ex(2'b01, 3'b101, 32'h2002, 32'h0, 0);
    wait_idle();
    push_req(0, 32'h5008, 0, 4'b0000, 32'hCAFEF00D, 3, 4);
    push_wb(11, 32'hCAFEF00D, 0);
    drive_ex(2'b01, 3'b010, 32'h5008, 32'h0, 11);
    n = 0;
    while (!bus.wb_valid_out && n < 40) begin
      chk("busy_ready", 32'(bus.ex_ready_out), 0);
      tick(); n++;
    end
    wait_idle();
    chk("ld_slow_lat", first_valid_cyc - acc_cyc, 9);
    wb_rdy_man = 0;
    tick();
    push_wb(7, 32'h000000A1, 0);
    drive_ex(2'b00, 3'b000, 32'h000000A1, 32'h0, 7);
    push_wb(9, 32'h000000B2, 0);
    bus.ex_valid_in = 1; bus.ex_op_in = 2'b00; bus.ex_addr_in = 32'h000000B2; bus.ex_rd_in = 9;
    repeat (3) begin
      tick();
      chk("hold_ready", 32'(bus.ex_ready_out), 0);
      chk("hold_data", bus.wb_data_out, 32'h000000A1);
    end
    wb_rdy_man = 1;
    tick();
    chk("drain_ready", 32'(bus.ex_ready_out), 1);
    tick();
    bus.ex_valid_in = 0;
    chk("drain_valid", 32'(bus.wb_valid_out), 1);
    chk("drain_data", bus.wb_data_out, 32'h000000B2);
    chk("drain_rd", 32'(bus.wb_rd_out), 9);
    wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    push_wb(12, 32'h00003001, 1);
`else
    push_req(0, 32'h3000, 0, 4'b0000, 32'h11223344, 0, 0);
    push_wb(12, 32'h11223344, 0);
`endif
    drive_ex(2'b01, 3'b010, 32'h3001, 32'h0, 12);
    wait_idle();
    push_req(0, 32'h4000, 0, 4'b0000, 32'h55AA55AA, 0, 6);
    drive_ex(2'b01, 3'b010, 32'h4000, 32'h0, 3);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_wb_valid", 32'(bus.wb_valid_out), 0);
    chk("abort_req_valid", 32'(bus.mem_req_valid_out), 0);
    chk("abort_ready", 32'(bus.ex_ready_out), 1);
    repeat (10) begin
      tick();
      chk("abort_no_wb", 32'(bus.wb_valid_out), 0);
    end
    wait_idle();
    wb_rand = 1;
    noise = 1;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      w = $urandom;
      rdat = $urandom;
      rd = 5'($urandom);
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (op == 2'b01 || op == 2'b10) && m_mis(op == 2'b01, f3, a);
`else
      mis = 0;
`endif
      if ((op == 2'b01 || op == 2'b10) && !mis) begin
        push_req(op == 2'b10, {a[31:2], 2'b00}, m_wdata(f3, w), op == 2'b10 ? m_strb(f3, a) : 4'b0000,
                 rdat, $urandom_range(0, 3), $urandom_range(0, 3));
        if (op == 2'b01) push_wb(rd, m_load(f3, a, rdat), 0);
      end else push_wb(rd, a, mis);
      drive_ex(op, f3, a, w, rd);
      if ($urandom_range(0, 3) == 0) tick();
    end
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
